// File: rtl/alvio_wr_sched_pkg.sv
// Shared types and helpers for the active-list violation RAM write scheduler.
package alvio_pkg;

  typedef enum logic [0:0] {StInit, StRun} sched_state_t;

  localparam int unsigned DepthDefault   = 16;
  localparam int unsigned SweepLast      = DepthDefault - 1;
  localparam int unsigned MaxReq         = 32;
  localparam int unsigned MaxReqW        = 5;

  function automatic int unsigned sweep_last(input int unsigned depth);
    return depth - 1;
  endfunction

  // First valid requester at or after rr, wrapping modulo n; one-hot result.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                                input int unsigned       rr,
                                                input int unsigned       n);
    logic [MaxReq-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = (rr + i) % n;
      if (i < n && !found && valid[idx[MaxReqW-1:0]]) begin
        gnt[idx[MaxReqW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/alvio_wr_sched_if.sv
// Requester-side valid/ready bundle for the violation RAM write scheduler.
interface alvio_wr_sched_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned INDEX   = 4,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*INDEX-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/alvio_rr_arbiter.sv
// Round-robin picker; pointer moves past the winner whenever a grant is issued.
module alvio_rr_arbiter
  import alvio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o
);
  localparam int unsigned RrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RrW-1:0]    rr_q, rr_d;
  logic [MaxReq-1:0] pick;

  always_comb begin
    pick    = rr_pick(MaxReq'(valid_i), 32'(rr_q), NUM_REQ);
    grant_o = enable_i ? pick[NUM_REQ-1:0] : '0;
    rr_d    = rr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_o[i]) rr_d = RrW'((i + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/alvio_wr_sched.sv
// Violation RAM write-port sequencer: zero-fill sweep after reset/clear, then
// round-robin sharing of the single write port between reporters.
module alvio_wr_sched
  import alvio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned INDEX   = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  alvio_wr_sched_if.slave   req,
  output logic              we_o,
  output logic [INDEX-1:0]  addr_wr_o,
  output logic [WIDTH-1:0]  data_wr_o,
  output logic              ram_ready_o,
  output logic              addr_err_o
);
  localparam logic [INDEX-1:0] LastIdx = INDEX'(sweep_last(DEPTH));

  sched_state_t       state_q, state_d;
  logic [INDEX-1:0]   ptr_q;
  logic               we_q, ram_ready_q, addr_err_q;
  logic [INDEX-1:0]   addr_q;
  logic [WIDTH-1:0]   data_q;
  logic [NUM_REQ-1:0] grant;
  logic               run_open, hs, addr_oob;
  logic [INDEX-1:0]   sel_addr;
  logic [WIDTH-1:0]   sel_data;

  // Grants only open once the sweep has completed and no clear is pending.
  assign run_open = reset && (state_q == StRun) && ram_ready_q && !clear_i;

  alvio_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (req.req_valid),
    .enable_i (run_open),
    .grant_o  (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StInit;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StInit;
    end else begin
      unique case (state_q)
        StInit:  if (ptr_q == LastIdx) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StInit;
      endcase
    end
  end

  always_comb begin
    req.req_ready = grant;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req.req_addr[i*INDEX +: INDEX];
        sel_data = req.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign hs       = |grant;
  assign addr_oob = 32'(sel_addr) >= DEPTH;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ram_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else if (clear_i) begin
      ptr_q       <= '0;
      we_q        <= 1'b0;
      ram_ready_q <= 1'b0;
    end else if (state_q == StInit) begin
      we_q        <= 1'b1;
      addr_q      <= ptr_q;
      data_q      <= '0;
      ptr_q       <= ptr_q + 1'b1;
      ram_ready_q <= 1'b0;
    end else begin
      ram_ready_q <= 1'b1;
      if (hs && addr_oob) begin
        we_q       <= 1'b0;
        addr_err_q <= 1'b1;
      end else if (hs) begin
        we_q   <= 1'b1;
        addr_q <= sel_addr;
        data_q <= sel_data;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign we_o        = we_q;
  assign addr_wr_o   = addr_q;
  assign data_wr_o   = data_q;
  assign ram_ready_o = ram_ready_q;
  assign addr_err_o  = addr_err_q;

endmodule
